// File: rtl/matmul_sched_pkg.sv
// Shared types for the matmul tile scheduler: FSM state, latched job command, perf counter width.
package matmul_sched_pkg;

    localparam int SCHED_TW = 8;
    localparam int PERF_W   = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [SCHED_TW-1:0] tiles_m;
        logic [SCHED_TW-1:0] tiles_n;
        logic [SCHED_TW-1:0] tiles_k;
        logic [1:0]          halved;
        logic [3:0]          bitsize_a;
        logic [3:0]          bitsize_b;
    } sched_cmd_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/matmul_tile_iter.sv
// Nested tile index counters: k innermost, then n, then m.
module matmul_tile_iter
    import matmul_sched_pkg::*;
#(
    parameter int TW = SCHED_TW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [TW-1:0] tiles_m_i,
    input  logic [TW-1:0] tiles_n_i,
    input  logic [TW-1:0] tiles_k_i,
    input  logic          step_k_i,
    input  logic          step_mn_i,
    input  logic          clear_i,
    output logic [TW-1:0] tile_m_o,
    output logic [TW-1:0] tile_n_o,
    output logic [TW-1:0] tile_k_o,
    output logic          last_k_o,
    output logic          last_mn_o
);

    logic [TW-1:0] m_q, n_q, k_q;
    logic          last_m_s, last_n_s;

    // Compare against count-1 so a count of 2^TW-1 never needs an index of 2^TW.
    assign last_k_o  = (k_q == tiles_k_i - TW'(1));
    assign last_n_s  = (n_q == tiles_n_i - TW'(1));
    assign last_m_s  = (m_q == tiles_m_i - TW'(1));
    assign last_mn_o = last_m_s && last_n_s;

    assign tile_m_o = m_q;
    assign tile_n_o = n_q;
    assign tile_k_o = k_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else if (step_mn_i) begin
            k_q <= '0;
            if (last_n_s) begin
                n_q <= '0;
                m_q <= last_m_s ? '0 : m_q + TW'(1);
            end else begin
                n_q <= n_q + TW'(1);
            end
        end else if (step_k_i && !last_k_o) begin
            k_q <= k_q + TW'(1);
        end
    end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks an MxNxK tile grid onto one matmul datapath and drives the external accumulator.
// Optional MATMUL_SCHED_PERF_EN adds saturating busy/stall cycle counters.
module matmul_tile_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int TW = SCHED_TW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [TW-1:0] cmd_tiles_m_i,
    input  logic [TW-1:0] cmd_tiles_n_i,
    input  logic [TW-1:0] cmd_tiles_k_i,
    input  logic [1:0]    cmd_halved_i,
    input  logic [3:0]    cmd_bitsize_a_i,
    input  logic [3:0]    cmd_bitsize_b_i,
    output logic          mm_valid_o,
    input  logic          mm_ready_i,
    input  logic          mm_valid_i,
    output logic          mm_ready_o,
    output logic [1:0]    mm_halved_o,
    output logic [3:0]    mm_bitsize_a_o,
    output logic [3:0]    mm_bitsize_b_o,
    output logic [TW-1:0] tile_m_o,
    output logic [TW-1:0] tile_n_o,
    output logic [TW-1:0] tile_k_o,
    output logic          acc_clear_o,
    output logic          acc_we_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          done_o
`ifdef MATMUL_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_busy_o,
    output logic [PERF_W-1:0] perf_stall_o
`endif
);

    sched_state_e state_q;
    sched_cmd_t   cmd_q;
    logic         cmd_ready_q, mm_valid_q, mm_ready_q, acc_clear_q, out_valid_q, done_q;
    logic         accept_s, zero_job_s, step_k_s, step_mn_s, last_k_s, last_mn_s;

    assign accept_s   = cmd_ready_q && cmd_valid_i;
    assign zero_job_s = (cmd_tiles_m_i == '0) || (cmd_tiles_n_i == '0) || (cmd_tiles_k_i == '0);
    assign step_k_s   = (state_q == WAIT) && mm_valid_i;
    assign step_mn_s  = (state_q == WRITE) && out_ready_i;

    matmul_tile_iter #(.TW(TW)) u_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tiles_m_i (cmd_q.tiles_m),
        .tiles_n_i (cmd_q.tiles_n),
        .tiles_k_i (cmd_q.tiles_k),
        .step_k_i  (step_k_s),
        .step_mn_i (step_mn_s),
        .clear_i   (accept_s),
        .tile_m_o  (tile_m_o),
        .tile_n_o  (tile_n_o),
        .tile_k_o  (tile_k_o),
        .last_k_o  (last_k_s),
        .last_mn_o (last_mn_s)
    );

    // Scheduler FSM; every handshake output is a register set alongside the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b1;
            mm_valid_q  <= 1'b0;
            mm_ready_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        cmd_q.tiles_m   <= cmd_tiles_m_i;
                        cmd_q.tiles_n   <= cmd_tiles_n_i;
                        cmd_q.tiles_k   <= cmd_tiles_k_i;
                        cmd_q.halved    <= cmd_halved_i;
                        cmd_q.bitsize_a <= cmd_bitsize_a_i;
                        cmd_q.bitsize_b <= cmd_bitsize_b_i;
                        cmd_ready_q     <= 1'b0;
                        if (zero_job_s) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            mm_valid_q  <= 1'b1;
                            acc_clear_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mm_ready_i) begin
                        state_q     <= WAIT;
                        mm_valid_q  <= 1'b0;
                        acc_clear_q <= 1'b0;
                        mm_ready_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mm_valid_i) begin
                        mm_ready_q <= 1'b0;
                        if (last_k_s) begin
                            state_q     <= WRITE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            mm_valid_q  <= 1'b1;
                            acc_clear_q <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (last_mn_s) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Next output tile restarts at k=0, so its first issue clears C.
                            state_q     <= ISSUE;
                            mm_valid_q  <= 1'b1;
                            acc_clear_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    mm_valid_q  <= 1'b0;
                    mm_ready_q  <= 1'b0;
                    acc_clear_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Ready is gated by reset so it reads 0 throughout reset and rises the first cycle out of it.
    assign cmd_ready_o    = cmd_ready_q && !rst_i;
    assign mm_valid_o     = mm_valid_q;
    assign mm_ready_o     = mm_ready_q;
    assign acc_we_o       = mm_ready_q && mm_valid_i;
    assign acc_clear_o    = acc_clear_q;
    assign out_valid_o    = out_valid_q;
    assign done_o         = done_q;
    assign mm_halved_o    = cmd_q.halved;
    assign mm_bitsize_a_o = cmd_q.bitsize_a;
    assign mm_bitsize_b_o = cmd_q.bitsize_b;

`ifdef MATMUL_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_busy_q, perf_stall_q;

    // Busy and stall cycle counters, restarted by each accepted job.
    always_ff @(posedge clk_i) begin
        if (rst_i || accept_s) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q != IDLE) begin
                perf_busy_q <= sat_inc(perf_busy_q);
            end
            if (((state_q == ISSUE) && !mm_ready_i) || ((state_q == WRITE) && !out_ready_i)) begin
                perf_stall_q <= sat_inc(perf_stall_q);
            end
        end
    end

    assign perf_busy_o  = perf_busy_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
